// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage: FSM states, buffered {pc, instr} entry.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package instr_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto an instruction boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry buffer of fetched {pc, instr} pairs; head is read combinationally.
// Latency: an entry pushed this cycle is visible at the head the next cycle.
// Backpressure: caller must not push when full unless popping; flush beats push/pop.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [PTR_W:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  // Storage is not reset: slots are only observable while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointer and occupancy bookkeeping; a flush empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
    end
  end

  // Empty buffer presents an all-zero head.
  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

endmodule

// File: rtl/instr_fetch.sv
// PC generation and fetch buffer in front of a zero-latency IMEM. Optional macro: FETCH_MISALIGN_CHK_EN.
// Latency: one bubble after reset release, then one instruction per cycle; head valid the cycle after fetch.
// Backpressure: if_ready low fills the buffer, then the PC and Instr_Addr hold; redirect flushes everything.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  parameter  int          DEPTH    = 2,
  localparam int          PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      Instr_Addr,
  input  logic [31:0]      Instr_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus4,
  output logic [PTR_W:0]   if_count
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic             if_misalign
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         push;
  logic         pop;
  logic         redir_bad;
  logic [31:0]  redir_target;
  fetch_entry_t head;
  fetch_entry_t new_entry;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_flag;
  assign redir_bad   = (redirect_pc[1:0] != 2'b00);
  assign if_misalign = misalign_flag;
`else
  // Low target bits are dropped silently when the check is not built in.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_bad = 1'b0;
`endif

  assign redir_target = word_align(redirect_pc);

  // Consumer handshake; a redirect in the same cycle discards it via flush.
  assign pop  = if_valid && if_ready;
  // Fetch only in RUN, never on a redirect or halt cycle, and only if a slot frees up.
  assign push = (state == RUN) && !redirect_valid && !halt_req &&
                ((if_count != FULL_CNT) || pop);

  assign new_entry = '{pc: pc, instr: Instr_rdata};

  // FSM and PC register; a redirect overrides everything else after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_flag <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc    <= redir_target;
      state <= redir_bad ? HALTED : RUN;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_flag <= redir_bad;
`endif
    end else begin
      unique case (state)
        BOOT:    state <= RUN;
        RUN: begin
          if (halt_req)  state <= HALTED;
          else if (push) pc    <= pc + XLEN'(INSTR_BYTES);
        end
        HALTED:  state <= HALTED;
        default: state <= BOOT;
      endcase
    end
  end

  // Flushing during BOOT is harmless since the buffer is already empty.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .push_entry (new_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (if_count)
  );

  assign Instr_Addr  = pc;
  assign if_valid    = (if_count != '0);
  assign if_instr    = head.instr;
  assign if_pc       = head.pc;
  assign if_pc_plus4 = if_valid ? (head.pc + XLEN'(INSTR_BYTES)) : '0;

endmodule
